// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4 arbiter.
// Build option: ARB_FIXED_PRIO_EN selects fixed m0 priority instead of round-robin.
package axi_arb_pkg;

    localparam int ID_W    = 4;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    localparam logic [RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WDATA = 3'd4,
        WRESP = 3'd5
    } arb_state_e;

endpackage

// File: rtl/axi_arb_pick.sv
// Combinational 2-way picker: round-robin on last winner, or fixed m0 priority
// when ARB_FIXED_PRIO_EN is defined.
module axi_arb_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        case (req)
            2'b10: winner = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
            2'b11: winner = 1'b0;
`else
            2'b11: winner = ~last;
`endif
            default: winner = 1'b0;
        endcase
    end

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/axi_arbiter_2x1.sv
// Shares one AXI4 slave between m0 (IFU) and m1 (LSU), one burst in flight at a time.
// Build option: ARB_FIXED_PRIO_EN (fixed m0 priority instead of round-robin).
module axi_arbiter_2x1
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0
    input  logic                  m0_awvalid,
    output logic                  m0_awready,
    input  logic [ADDR_W-1:0]     m0_awaddr,
    input  logic [ID_W-1:0]       m0_awid,
    input  logic [LEN_W-1:0]      m0_awlen,
    input  logic [SIZE_W-1:0]     m0_awsize,
    input  logic [BURST_W-1:0]    m0_awburst,
    input  logic                  m0_wvalid,
    output logic                  m0_wready,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    input  logic                  m0_wlast,
    output logic                  m0_bvalid,
    input  logic                  m0_bready,
    output logic [RESP_W-1:0]     m0_bresp,
    output logic [ID_W-1:0]       m0_bid,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic [ID_W-1:0]       m0_arid,
    input  logic [LEN_W-1:0]      m0_arlen,
    input  logic [SIZE_W-1:0]     m0_arsize,
    input  logic [BURST_W-1:0]    m0_arburst,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [RESP_W-1:0]     m0_rresp,
    output logic                  m0_rlast,
    output logic [ID_W-1:0]       m0_rid,
    // master 1
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic [ID_W-1:0]       m1_awid,
    input  logic [LEN_W-1:0]      m1_awlen,
    input  logic [SIZE_W-1:0]     m1_awsize,
    input  logic [BURST_W-1:0]    m1_awburst,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic                  m1_wlast,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    output logic [RESP_W-1:0]     m1_bresp,
    output logic [ID_W-1:0]       m1_bid,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic [ID_W-1:0]       m1_arid,
    input  logic [LEN_W-1:0]      m1_arlen,
    input  logic [SIZE_W-1:0]     m1_arsize,
    input  logic [BURST_W-1:0]    m1_arburst,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [RESP_W-1:0]     m1_rresp,
    output logic                  m1_rlast,
    output logic [ID_W-1:0]       m1_rid,
    // slave
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic [ID_W-1:0]       s_awid,
    output logic [LEN_W-1:0]      s_awlen,
    output logic [SIZE_W-1:0]     s_awsize,
    output logic [BURST_W-1:0]    s_awburst,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wlast,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    input  logic [RESP_W-1:0]     s_bresp,
    input  logic [ID_W-1:0]       s_bid,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [ADDR_W-1:0]     s_araddr,
    output logic [ID_W-1:0]       s_arid,
    output logic [LEN_W-1:0]      s_arlen,
    output logic [SIZE_W-1:0]     s_arsize,
    output logic [BURST_W-1:0]    s_arburst,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [RESP_W-1:0]     s_rresp,
    input  logic                  s_rlast,
    input  logic [ID_W-1:0]       s_rid,
    // observation
    output logic [2:0]            dbg_state,
    output logic                  dbg_gnt
);

    // Handshakes: a beat transfers on a rising clk edge where valid and ready are both 1;
    // valid/ready of the granted master are wired straight through, everything else reads 0.

    arb_state_e state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_q, last_d;
    logic       pick_winner;

    logic [1:0] awv, wv, wl, br, arv, rr, req;

    assign awv = {m1_awvalid, m0_awvalid};
    assign wv  = {m1_wvalid,  m0_wvalid};
    assign wl  = {m1_wlast,   m0_wlast};
    assign br  = {m1_bready,  m0_bready};
    assign arv = {m1_arvalid, m0_arvalid};
    assign rr  = {m1_rready,  m0_rready};
    // A pending write or read address counts as a request.
    assign req = awv | arv;

    axi_arb_pick u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = pick_winner;
                    // A master's write goes first so its store is seen by its later load.
                    state_d = awv[pick_winner] ? WADDR : RADDR;
                end
            end
            RADDR: if (arv[gnt_q] && s_arready) state_d = RDATA;
            RDATA: begin
                if (s_rvalid && rr[gnt_q] && s_rlast) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end
            end
            WADDR: if (awv[gnt_q] && s_awready) state_d = WDATA;
            WDATA: if (wv[gnt_q] && s_wready && wl[gnt_q]) state_d = WRESP;
            WRESP: begin
                if (s_bvalid && br[gnt_q]) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_awready = 1'b0;
        m0_wready  = 1'b0;
        m0_bvalid  = 1'b0;
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        case (state_q)
            RADDR: begin
                s_arvalid  = arv[gnt_q];
                m0_arready = s_arready & ~gnt_q;
                m1_arready = s_arready &  gnt_q;
            end
            RDATA: begin
                s_rready  = rr[gnt_q];
                m0_rvalid = s_rvalid & ~gnt_q;
                m1_rvalid = s_rvalid &  gnt_q;
            end
            WADDR: begin
                s_awvalid  = awv[gnt_q];
                m0_awready = s_awready & ~gnt_q;
                m1_awready = s_awready &  gnt_q;
            end
            WDATA: begin
                s_wvalid  = wv[gnt_q];
                m0_wready = s_wready & ~gnt_q;
                m1_wready = s_wready &  gnt_q;
            end
            WRESP: begin
                s_bready  = br[gnt_q];
                m0_bvalid = s_bvalid & ~gnt_q;
                m1_bvalid = s_bvalid &  gnt_q;
            end
            default: ;
        endcase
    end

    // Payloads follow the grant; only the valid/ready qualifiers are gated by state.
    assign s_awaddr  = gnt_q ? m1_awaddr  : m0_awaddr;
    assign s_awid    = gnt_q ? m1_awid    : m0_awid;
    assign s_awlen   = gnt_q ? m1_awlen   : m0_awlen;
    assign s_awsize  = gnt_q ? m1_awsize  : m0_awsize;
    assign s_awburst = gnt_q ? m1_awburst : m0_awburst;
    assign s_wdata   = gnt_q ? m1_wdata   : m0_wdata;
    assign s_wstrb   = gnt_q ? m1_wstrb   : m0_wstrb;
    assign s_wlast   = gnt_q ? m1_wlast   : m0_wlast;
    assign s_araddr  = gnt_q ? m1_araddr  : m0_araddr;
    assign s_arid    = gnt_q ? m1_arid    : m0_arid;
    assign s_arlen   = gnt_q ? m1_arlen   : m0_arlen;
    assign s_arsize  = gnt_q ? m1_arsize  : m0_arsize;
    assign s_arburst = gnt_q ? m1_arburst : m0_arburst;

    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m0_rid   = s_rid;
    assign m0_bresp = s_bresp;
    assign m0_bid   = s_bid;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;
    assign m1_rid   = s_rid;
    assign m1_bresp = s_bresp;
    assign m1_bid   = s_bid;

    assign dbg_state = state_q;
    assign dbg_gnt   = gnt_q;

endmodule
